// File: rtl/fb_pixel_writer.sv
// Pixel-stream sink: small FIFO, off-screen clipping, (x,y) -> linear address, framebuffer write port.
// Optional clip counter output enabled by defining FB_CLIP_COUNT_EN.
module fb_pixel_writer #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        CounterX,
  input  logic [7:0]        CounterY,
  input  logic [11:0]       color,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              fb_busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
`ifdef FB_CLIP_COUNT_EN
  output logic [15:0]       clip_count,
`endif
  output logic              fb_we
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 28;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [11:0]       r_data;

  logic              w_ready;
  logic              w_in_range;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic [7:0]        w_head_x;
  logic [7:0]        w_head_y;
  logic [11:0]       w_head_color;
  logic [ADDR_W-1:0] w_addr;

  // Ready depends only on occupancy so upstream never sees a valid->ready loop.
  assign w_ready    = (r_count != FULL_CNT);
  assign w_in_range = ({1'b0, CounterX} < 9'(FB_W)) && ({1'b0, CounterY} < 9'(FB_H));
  assign w_accept   = pix_valid & w_ready;
  assign w_push     = w_accept & w_in_range;
  assign w_pop      = (r_count != '0) & ~fb_busy;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_x     = w_head[27:20];
  assign w_head_y     = w_head[19:12];
  assign w_head_color = w_head[11:0];
  assign w_addr       = ADDR_W'(w_head_y) * ADDR_W'(FB_W) + ADDR_W'(w_head_x);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {CounterX, CounterY, color};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: address/data only move on a pop, so they hold while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_pop ? ST_WRITE : ST_IDLE;
      if (w_pop) begin
        r_addr <= w_addr;
        r_data <= w_head_color;
      end
    end
  end

`ifdef FB_CLIP_COUNT_EN
  logic [15:0] r_clip_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clip_count <= '0;
    end else if (w_accept && !w_in_range && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign clip_count = r_clip_count;
`endif

  assign pix_ready = w_ready;
  assign fb_we     = (r_state == ST_WRITE);
  assign fb_addr   = r_addr;
  assign fb_data   = r_data;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: reset, latency, clipping, back-pressure, streaming,
// mid-stream reset and a toggling busy burst.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cx;
  logic [7:0]  cy;
  logic [11:0] color;
  logic        pix_valid;
  logic        pix_ready;
  logic        fb_busy;
  logic [14:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_we;
`ifdef FB_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int errors = 0;
  int checks = 0;
  bit stall_seen = 1'b0;

  int   cyc = 0;
  logic busy_at_edge = 1'b0;

  logic [14:0] wq_addr [$];
  logic [11:0] wq_data [$];
  int          wq_cyc  [$];
  logic        wq_busy [$];

  int t3_addr [5] = '{481, 651, 821, 991, 1161};
  int t6_addr [8] = '{8100, 8261, 8422, 8583, 8744, 8905, 9066, 9227};

  always #5 clk = ~clk;

  fb_pixel_writer dut (
    .clk       (clk),
    .reset     (reset),
    .CounterX  (cx),
    .CounterY  (cy),
    .color     (color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .fb_busy   (fb_busy),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
`ifdef FB_CLIP_COUNT_EN
    .clip_count(clip_count),
`endif
    .fb_we     (fb_we)
  );

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= fb_busy;
  end

  // Write monitor: one record per cycle with the strobe high, tagged with the pop edge.
  always @(negedge clk) begin
    if (fb_we) begin
      wq_addr.push_back(fb_addr);
      wq_data.push_back(fb_data);
      wq_cyc.push_back(cyc);
      wq_busy.push_back(busy_at_edge);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    wq_busy.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic put(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
    int g = 0;
    cx = x; cy = y; color = c; pix_valid = 1'b1;
    while (!pix_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("put_timeout", 32'd0, 32'd1);
    if (g != 0) stall_seen = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cx = '0; cy = '0; color = '0; pix_valid = 1'b0; fb_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we",    32'(fb_we),   32'd0);
    check("rst_addr",  32'(fb_addr), 32'd0);
    check("rst_data",  32'(fb_data), 32'd0);
`ifdef FB_CLIP_COUNT_EN
    check("rst_clip",  32'(clip_count), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(pix_ready), 32'd1);

    // 1: single pixel latency
    put(8'd5, 8'd2, 12'hF00);
    pix_valid = 1'b0;
    check("t1_we_edgeN", 32'(fb_we), 32'd0);
    @(negedge clk);
    check("t1_we",   32'(fb_we),   32'd1);
    check("t1_addr", 32'(fb_addr), 32'd325);
    check("t1_data", 32'(fb_data), 32'hF00);
    @(negedge clk);
    check("t1_we_drop", 32'(fb_we), 32'd0);
    check("t1_addr_hold", 32'(fb_addr), 32'd325);
    idle(2);
    clear_log();

    // 2: corners and clipped pixels
    put(8'd0,   8'd0,   12'h111);
    put(8'd159, 8'd119, 12'h222);
    put(8'd160, 8'd0,   12'h333);
    put(8'd0,   8'd120, 12'h444);
    idle(6);
    check("t2_count", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      check("t2_addr0", 32'(wq_addr[0]), 32'd0);
      check("t2_data0", 32'(wq_data[0]), 32'h111);
      check("t2_addr1", 32'(wq_addr[1]), 32'd19199);
      check("t2_data1", 32'(wq_data[1]), 32'h222);
    end
`ifdef FB_CLIP_COUNT_EN
    check("t2_clip", 32'(clip_count), 32'd2);
`endif
    clear_log();

    // 3: back-pressure while fb_busy holds the FIFO full
    fb_busy = 1'b1;
    for (int i = 0; i < 4; i++) put(8'(i * 10 + 1), 8'(i + 3), 12'(12'hA00 + i));
    cx = 8'd41; cy = 8'd7; color = 12'hA04; pix_valid = 1'b1;
    check("t3_full_ready", 32'(pix_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_held_ready", 32'(pix_ready), 32'd0);
    check("t3_no_write",   32'(wq_addr.size()), 32'd0);
    fb_busy = 1'b0;
    stall_seen = 1'b0;
    put(8'd41, 8'd7, 12'hA04);
    check("t3_fifth_waited", 32'(stall_seen), 32'd1);
    idle(8);
    check("t3_count", 32'(wq_addr.size()), 32'd5);
    if (wq_addr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t3_addr%0d", i), 32'(wq_addr[i]), 32'(t3_addr[i]));
        check($sformatf("t3_data%0d", i), 32'(wq_data[i]), 32'(12'hA00 + i));
        check($sformatf("t3_cyc%0d", i),  32'(wq_cyc[i]),  32'(wq_cyc[0] + i));
      end
    end
    clear_log();

    // 4: continuous stream of 20 pixels
    stall_seen = 1'b0;
    for (int i = 0; i < 20; i++) put(8'(i * 7), 8'(i * 5), 12'(i + 12'h100));
    idle(5);
    check("t4_no_stall", 32'(stall_seen), 32'd0);
    check("t4_count", 32'(wq_addr.size()), 32'd20);
    if (wq_addr.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("t4_addr%0d", i), 32'(wq_addr[i]), 32'((i * 5) * 160 + i * 7));
        check($sformatf("t4_data%0d", i), 32'(wq_data[i]), 32'(i + 12'h100));
        check($sformatf("t4_cyc%0d", i),  32'(wq_cyc[i]),  32'(wq_cyc[0] + i));
      end
    end
    clear_log();

    // 5: reset with pixels queued and a write in flight
    fb_busy = 1'b1;
    for (int i = 0; i < 3; i++) put(8'(20 + i), 8'd9, 12'(12'h500 + i));
    pix_valid = 1'b0;
    fb_busy = 1'b0;
    @(negedge clk);
    check("t5_inflight_we", 32'(fb_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_we",    32'(fb_we),     32'd0);
    check("t5_rst_addr",  32'(fb_addr),   32'd0);
    check("t5_rst_ready", 32'(pix_ready), 32'd1);
    clear_log();
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    check("t5_no_stale", 32'(wq_addr.size()), 32'd0);
    check("t5_ready",    32'(pix_ready),      32'd1);
    clear_log();

    // 6: fb_busy toggling every cycle during an 8-pixel burst
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          fb_busy = ~fb_busy;
        end
        fb_busy = 1'b0;
      end
    join_none
    for (int i = 0; i < 8; i++) put(8'(100 + i), 8'(50 + i), 12'(12'h600 + i));
    idle(45);
    check("t6_count", 32'(wq_addr.size()), 32'd8);
    if (wq_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t6_addr%0d", i), 32'(wq_addr[i]), 32'(t6_addr[i]));
        check($sformatf("t6_data%0d", i), 32'(wq_data[i]), 32'(12'h600 + i));
        check($sformatf("t6_busy%0d", i), 32'(wq_busy[i]), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
